// File: rtl/fp_compare_pkg.sv
// Shared encodings for the fp compare/min/max unit: mode codes, CMP flag bit
// positions, canonical quiet NaN builder and FSM state type.
package fp_compare_pkg;

  localparam logic [2:0] MODE_CMP    = 3'd0;
  localparam logic [2:0] MODE_MIN    = 3'd1;
  localparam logic [2:0] MODE_MAX    = 3'd2;
  localparam logic [2:0] MODE_ABSCMP = 3'd3;

  localparam int FLAG_AEB = 0;
  localparam int FLAG_AGB = 1;
  localparam int FLAG_ALB = 2;
  localparam int FLAG_UN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Exponent all ones, only the mantissa MSB set, sign 0; valid for W <= 64.
  function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w+i] = 1'b1;
    r[man_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_compare_core.sv
// Classify, key-compare and result-select for one operand pair, followed by
// STAGES optional register stages. NaN handling only with FP_COMPARE_NAN_EN.
module fp_compare_core
  import fp_compare_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic [2:0]             mode,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   y
);

  localparam int W = 1 + EXP_W + MAN_W;

  logic [W-1:0] a_c, b_c, ka, kb, y_c;
  logic         both_zero, un, aeb, agb, alb;

`ifdef FP_COMPARE_NAN_EN
  localparam logic [63:0] QNAN64 = canonical_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN  = QNAN64[W-1:0];
  logic a_nan, b_nan;
`endif

  always_comb begin
    a_c = a;
    b_c = b;
    if (mode == MODE_ABSCMP) begin
      a_c[W-1] = 1'b0;
      b_c[W-1] = 1'b0;
    end
    // Sign-magnitude to monotonic unsigned key.
    ka = a_c[W-1] ? ~a_c : {1'b1, a_c[W-2:0]};
    kb = b_c[W-1] ? ~b_c : {1'b1, b_c[W-2:0]};
    both_zero = (a[W-2:0] == '0) && (b[W-2:0] == '0);
`ifdef FP_COMPARE_NAN_EN
    a_nan = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    b_nan = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
    un    = a_nan || b_nan;
`else
    un = 1'b0;
`endif
    aeb = !un && (both_zero || (ka == kb));
    agb = !un && !both_zero && (ka > kb);
    alb = !un && !both_zero && (ka < kb);

    y_c = '0;
    case (mode)
      MODE_CMP, MODE_ABSCMP: begin
        y_c[FLAG_AEB] = aeb;
        y_c[FLAG_AGB] = agb;
        y_c[FLAG_ALB] = alb;
        y_c[FLAG_UN]  = un;
      end
      MODE_MIN, MODE_MAX: begin
        // Opposite-signed zeros: MIN takes the negative one, MAX the positive.
        if (both_zero) y_c = (a[W-1] ^ (mode == MODE_MAX)) ? a : b;
        else           y_c = ((mode == MODE_MIN) ? agb : alb) ? b : a;
`ifdef FP_COMPARE_NAN_EN
        if (a_nan && b_nan) y_c = QNAN;
        else if (a_nan)     y_c = b;
        else if (b_nan)     y_c = a;
`endif
      end
      default: y_c = '0;
    endcase
  end

  generate
    if (STAGES == 0) begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clock, reset, clk_en};
      assign y = y_c;
    end else begin : g_pipe
      logic [W-1:0] stg [STAGES];
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) stg[i] <= '0;
        end else if (clk_en) begin
          stg[0] <= y_c;
          for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
        end
      end
      assign y = stg[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/fp_compare_unit.sv
// fp compare/min/max custom-instruction wrapper: operand registers, start/done
// FSM, latency counter. Optional NaN semantics via FP_COMPARE_NAN_EN.
module fp_compare_unit
  import fp_compare_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 start,
  input  logic [2:0]           n,
  input  logic [EXP_W+MAN_W:0] dataa,
  input  logic [EXP_W+MAN_W:0] datab,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output state_t               dbg_state
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int CW = $clog2(LATENCY + 1);

  // Handshake: start is taken only on an enabled edge in IDLE (no queueing);
  // done is high for exactly one enabled cycle, with result valid alongside.
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;
  logic [2:0]    op_n;
  logic [W-1:0]  op_a, op_b, core_y;

  fp_compare_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .STAGES(LATENCY - 1)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .clk_en(clk_en),
    .mode  (op_n),
    .a     (op_a),
    .b     (op_b),
    .y     (core_y)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        accept    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = (LATENCY == 1) ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt_nxt == CW'(LATENCY - 1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_n   <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      done   <= 1'b0;
    end else if (clk_en) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= (state == ST_DONE);
      if (accept) begin
        op_n <= n;
        op_a <= dataa;
        op_b <= datab;
      end
      if (state == ST_DONE) result <= core_y;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_fp_compare_unit.sv
// Directed bench for fp_compare_unit (LATENCY=2, binary32); NaN expectations
// follow whether FP_COMPARE_NAN_EN is defined.
module tb_fp_compare_unit;
  import fp_compare_pkg::*;

  logic        clock, reset, clk_en, start;
  logic [2:0]  n;
  logic [31:0] dataa, datab, result;
  logic        done;
  state_t      dbg_state;
  int          checks, errors;

  fp_compare_unit #(.EXP_W(8), .MAN_W(23), .LATENCY(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .clk_en   (clk_en),
    .start    (start),
    .n        (n),
    .dataa    (dataa),
    .datab    (datab),
    .result   (result),
    .done     (done),
    .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] mode,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int lat;
    n = mode; dataa = a; datab = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd2);
    check(tag, result, exp);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; n = 3'd0; dataa = '0; datab = '0;
    tick(); tick();
    check("rst_result", result, 32'h0);
    check("rst_done", done, 32'h0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();

    run_op("cmp_lt",       3'd0, 32'h3F800000, 32'h40000000, 32'h00000004);
    run_op("cmp_zeros",    3'd0, 32'h80000000, 32'h00000000, 32'h00000001);
    run_op("max_zeros",    3'd2, 32'h80000000, 32'h00000000, 32'h00000000);
    run_op("min_zeros",    3'd1, 32'h00000000, 32'h80000000, 32'h80000000);
    run_op("min_neg",      3'd1, 32'hBF800000, 32'h40000000, 32'hBF800000);
    run_op("abscmp",       3'd3, 32'hBF800000, 32'h40000000, 32'h00000004);
    run_op("cmp_neg",      3'd0, 32'hBF800000, 32'h40000000, 32'h00000004);
    run_op("max_neg",      3'd2, 32'hBF800000, 32'h40000000, 32'h40000000);
    run_op("cmp_eq",       3'd0, 32'h3F800000, 32'h3F800000, 32'h00000001);
    run_op("cmp_gt_ninf",  3'd0, 32'h40000000, 32'hFF800000, 32'h00000002);
    run_op("cmp_inf_max",  3'd0, 32'h7F800000, 32'h7F7FFFFF, 32'h00000002);
    run_op("min_inf",      3'd1, 32'h7F800000, 32'h7F7FFFFF, 32'h7F7FFFFF);
    run_op("abscmp_gt",    3'd3, 32'hC0400000, 32'h40000000, 32'h00000002);
    run_op("max_negs",     3'd2, 32'hC0400000, 32'hC0000000, 32'hC0000000);
    run_op("reserved",     3'd5, 32'h3F800000, 32'h40000000, 32'h00000000);
`ifdef FP_COMPARE_NAN_EN
    run_op("nan_cmp",      3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000008);
    run_op("nan_max",      3'd2, 32'h7FC00000, 32'h3F800000, 32'h3F800000);
    run_op("nan_min_both", 3'd1, 32'h7FC00000, 32'hFFC00000, 32'h7FC00000);
`else
    run_op("nan_cmp",      3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000002);
    run_op("nan_max",      3'd2, 32'h7FC00000, 32'h3F800000, 32'h7FC00000);
    run_op("nan_min_both", 3'd1, 32'h7FC00000, 32'hFFC00000, 32'hFFC00000);
`endif

    // Result held after done, done low, FSM idle.
    run_op("hold_op", 3'd2, 32'h3F800000, 32'h40000000, 32'h40000000);
    tick(); tick(); tick();
    check("hold_result", result, 32'h40000000);
    check("hold_done", done, 32'h0);
    check("hold_state", dbg_state, ST_IDLE);

    // start held high: accepted at T and T+3 only.
    n = 3'd0; dataa = 32'h3F800000; datab = 32'h40000000; start = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) start = 1'b0;
      tick();
      check($sformatf("held_done_%0d", k), done, (k == 2 || k == 5) ? 32'd1 : 32'd0);
      if (k == 2) begin
        check("held_res1", result, 32'h00000004);
        n = 3'd2;
      end
      if (k == 5) check("held_res2", result, 32'h40000000);
    end

    // clk_en low for three cycles while busy delays done by three.
    tick();
    n = 3'd0; dataa = 32'h40000000; datab = 32'h3F800000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      clk_en = (k >= 1 && k <= 3) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("clken_done_%0d", k), done, (k == 5) ? 32'd1 : 32'd0);
    end
    clk_en = 1'b1;
    check("clken_result", result, 32'h00000002);

    // done pulse stretches while clk_en is low.
    run_op("stretch_op", 3'd0, 32'h3F800000, 32'h40000000, 32'h00000004);
    clk_en = 1'b0;
    tick();
    check("stretch_done1", done, 32'd1);
    tick();
    check("stretch_done2", done, 32'd1);
    clk_en = 1'b1;
    tick();
    check("stretch_done3", done, 32'd0);
    check("stretch_result", result, 32'h00000004);

    // Reset at T+1 aborts the operation; a new start at T+3 completes at T+5.
    n = 3'd0; dataa = 32'h40000000; datab = 32'h3F800000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();
    check("abort_done_t2", done, 32'd0);
    n = 3'd0; dataa = 32'h3F800000; datab = 32'h3F800000; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_done_t3", done, 32'd0);
    tick();
    check("abort_done_t4", done, 32'd0);
    tick();
    check("restart_done", done, 32'd1);
    check("restart_result", result, 32'h00000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_compare_unit.md
# fp_compare_unit

Parametrised floating-point compare/min/max unit for the floating-arithmetic custom-instruction datapath. Next-generation compare wrapper: native sign-magnitude comparator, configurable format and pipeline latency, selectable operation mode, explicit start/done handshake. Sits behind the processor custom-instruction port, beside the other fp arithmetic wrappers.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 23, mantissa width; W = 1+EXP_W+MAN_W (32 default)
- LATENCY, 2, cycles from accepted start to done; legal 1..8
- clock  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  global enable; low freezes all state (pipeline, counter, FSM)
- start  in  1  operation request, sampled when clk_en=1
- n  in  3  mode select, sampled with start
- dataa  in  W  operand A, sampled with start
- datab  in  W  operand B, sampled with start
- result  out  W  result, held until next accepted start
- done  out  1  one-cycle pulse, result valid

## Operation
- Modes (n): 0 CMP: result = {0, un, alb, agb, aeb} in bits [3:0]; 1 MIN: smaller operand; 2 MAX: larger operand; 3 ABSCMP: as CMP on |a|,|b|; 4-7 reserved -> result 0, done still pulses.
- Ordering: key = sign ? ~x : x with MSB forced 1; unsigned key compare. +0 and -0 equal (aeb=1).
- MIN/MAX tie (+0 vs -0): MIN returns -0, MAX returns +0; equal otherwise returns dataa.
- NaN (exp all ones, mantissa != 0): un=1, aeb=agb=alb=0. MIN/MAX with one NaN returns other operand; both NaN returns canonical qNaN (exp all ones, mantissa MSB only, sign 0).
- Infinities compare as ordinary extreme values.
- FSM: IDLE -> BUSY on accepted start (clk_en=1, start=1); BUSY counts LATENCY-1 cycles -> DONE; DONE pulses done, returns IDLE. start in BUSY or DONE ignored (no queueing).
- Start in the cycle after DONE accepted normally (back-to-back every LATENCY+1 cycles).

## Timing
- Reset values: result=0, done=0, FSM=IDLE, counter=0, pipeline registers 0.
- Operands/mode registered at accepted start (edge T); done=1 during cycle T+LATENCY, result updated at same edge.
- clk_en=0: every register holds; a done pulse in progress stretches until clk_en returns, then deasserts next enabled edge.
- Reset asserted mid-operation: immediately clears to reset values; no done for the aborted operation.
- Counter width $clog2(LATENCY+1); no wrap possible, saturates at LATENCY-1 then clears.
- LATENCY=1: compare fully combinational from registered operands; done at T+1.

## Configuration
- FP_COMPARE_NAN_EN defined: NaN detection, un flag, NaN rules of MIN/MAX and canonical qNaN as above.
- Not defined: no NaN classification; NaN patterns ordered by key like any value; result bit 3 constant 0. Saves comparator-side logic.

## Structure
- Package fp_compare_pkg: mode encodings (MODE_CMP, MODE_MIN, MODE_MAX, MODE_ABSCMP), flag bit positions, canonical qNaN function of EXP_W/MAN_W, FSM state type.
- One sub-module fp_compare_core: classify + key compare + result mux, parametrised by EXP_W/MAN_W, with optional internal register stages (LATENCY-1). Top holds operand registers, FSM, counter, done/result.

## Test plan
- Mode 0, a=0x3F800000 (1.0), b=0x40000000 (2.0), LATENCY=2 -> done at T+2, result=0x00000004 (alb).
- Mode 0, a=0x80000000, b=0x00000000 -> result=0x00000001; mode 2 same -> 0x00000000.
- Mode 1, a=0xBF800000 (-1.0), b=0x40000000 -> 0xBF800000; mode 3 same operands -> 0x00000004.
- With FP_COMPARE_NAN_EN: mode 0, a=0x7FC00000, b=0x3F800000 -> 0x00000008; mode 2 -> 0x3F800000; both NaN mode 1 -> 0x7FC00000.
- start held high 5 cycles, LATENCY=2 -> accepted at T and T+3 only, done at T+2 and T+5; clk_en low 3 cycles during BUSY delays done by 3.
- reset pulse at T+1 of an operation -> done never asserts, result=0; new start at T+3 completes normally at T+5.
